// File: rtl/ram_init_seq_pkg.sv
// Shared types for the RAM init sequencer: FSM state encoding and fill-pattern codes.
package ram_init_pkg;

  typedef enum logic [1:0] {
    ST_START,
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_t;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_CONST = 2'd1;
  localparam logic [1:0] PAT_ZERO  = 2'd2;
  localparam logic [1:0] PAT_NADDR = 2'd3;

endpackage

// File: rtl/ram_init_seq_sdp_core.sv
// Simple-dual-port storage: one write port, one registered read port,
// selectable read-during-write behaviour and out-of-range address guarding.
module ram_sdp_core #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 32,
  parameter int RDW_NEW = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              w_waddr_ok;
  logic              w_raddr_ok;
  logic              w_wr_en;

  // Range checks only exist when DEPTH leaves unused address codes.
  if (DEPTH == (1 << ADDR_W)) begin : g_full
    assign w_waddr_ok = 1'b1;
    assign w_raddr_ok = 1'b1;
  end else begin : g_part
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    assign w_waddr_ok = (i_waddr <= LAST);
    assign w_raddr_ok = (i_raddr <= LAST);
  end

  assign w_wr_en = i_we && w_waddr_ok;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_re;
      if (i_re) begin
        if (!w_raddr_ok)
          r_rdata <= '0;
        else if ((RDW_NEW != 0) && w_wr_en && (i_waddr == i_raddr))
          r_rdata <= i_wdata;
        else
          r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/ram_init_seq.sv
// Simple-dual-port RAM with a hardware fill sequencer that runs after reset
// or on request, writing one pattern word per cycle while user access is blocked.
module ram_init_seq
  import ram_init_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 32,
  parameter int INIT_ON_RESET = 1,
  parameter int INIT_MODE_RST = 0,
  parameter int RDW_NEW       = 0,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic [1:0]        init_mode,
  input  logic [DATA_W-1:0] init_value,
  output logic              init_busy,
  output logic              init_done,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_value;
  logic              w_busy, w_done;
  logic [DATA_W-1:0] w_pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_START;
      r_cnt   <= '0;
      r_mode  <= 2'(INIT_MODE_RST);
      r_value <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && init_req) begin
        r_mode  <= init_mode;
        r_value <= init_value;
        r_cnt   <= '0;
      end else if (r_state == ST_FILL) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_START: w_next = (INIT_ON_RESET != 0) ? ST_FILL : ST_IDLE;
      ST_IDLE:  if (init_req) w_next = ST_FILL;
      ST_FILL: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_START;
    endcase
  end

  always_comb begin
    w_pat = '0;
    case (r_mode)
      PAT_ADDR:  w_pat = DATA_W'(r_cnt);
      PAT_CONST: w_pat = r_value;
      PAT_ZERO:  w_pat = '0;
      PAT_NADDR: w_pat = ~DATA_W'(r_cnt);
      default:   w_pat = '0;
    endcase
  end

  assign init_busy = w_busy;
  assign init_done = w_done;

  // The fill engine owns the write port while busy; user reads are squashed.
  ram_sdp_core #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RDW_NEW (RDW_NEW)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_busy | we),
    .i_waddr  (w_busy ? r_cnt : waddr),
    .i_wdata  (w_busy ? w_pat : wdata),
    .i_re     (re & ~w_busy),
    .i_raddr  (raddr),
    .o_rdata  (rdata),
    .o_rvalid (rvalid)
  );

endmodule

// File: tb/tb_ram_init_seq.sv
// Directed bench for ram_init_seq: a default instance (A) and a DEPTH=20,
// DATA_W=16, no-auto-fill, RDW_NEW=1 instance (B), checked against a read scoreboard.
module tb_ram_init_seq;

  logic clk, rst_n;

  logic       a_init_req, a_init_busy, a_init_done, a_we, a_re, a_rvalid;
  logic [1:0] a_init_mode;
  logic [7:0] a_init_value, a_wdata, a_rdata;
  logic [4:0] a_waddr, a_raddr;

  logic        b_init_req, b_init_busy, b_init_done, b_we, b_re, b_rvalid;
  logic [1:0]  b_init_mode;
  logic [15:0] b_init_value, b_wdata, b_rdata;
  logic [4:0]  b_waddr, b_raddr;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_rd[2];

  ram_init_seq dut_a (
    .clk(clk), .rst_n(rst_n),
    .init_req(a_init_req), .init_mode(a_init_mode), .init_value(a_init_value),
    .init_busy(a_init_busy), .init_done(a_init_done),
    .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid)
  );

  ram_init_seq #(
    .DATA_W(16), .DEPTH(20), .INIT_ON_RESET(0), .INIT_MODE_RST(0), .RDW_NEW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .init_req(b_init_req), .init_mode(b_init_mode), .init_value(b_init_value),
    .init_busy(b_init_busy), .init_done(b_init_done),
    .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input bit b, input int mode, input int i, input logic [15:0] v);
    logic [15:0] r;
    case (mode)
      0:       r = 16'(i);
      1:       r = v;
      2:       r = '0;
      default: r = ~16'(i);
    endcase
    if (!b) r = r & 16'h00FF;
    return r;
  endfunction

  function automatic logic [15:0] rd(input bit b);
    return b ? b_rdata : {8'h00, a_rdata};
  endfunction
  function automatic logic rv(input bit b);
    return b ? b_rvalid : a_rvalid;
  endfunction
  function automatic logic busy(input bit b);
    return b ? b_init_busy : a_init_busy;
  endfunction
  function automatic logic done(input bit b);
    return b ? b_init_done : a_init_done;
  endfunction

  task automatic set_rd(input bit b, input logic en, input logic [4:0] addr);
    if (b) begin b_re = en; b_raddr = addr; end
    else   begin a_re = en; a_raddr = addr; end
  endtask

  task automatic set_wr(input bit b, input logic en, input logic [4:0] addr, input logic [15:0] data);
    if (b) begin b_we = en; b_waddr = addr; b_wdata = data; end
    else   begin a_we = en; a_waddr = addr; a_wdata = data[7:0]; end
  endtask

  task automatic set_req(input bit b, input logic en, input logic [1:0] mode, input logic [15:0] val);
    if (b) begin b_init_req = en; b_init_mode = mode; b_init_value = val; end
    else   begin a_init_req = en; a_init_mode = mode; a_init_value = val[7:0]; end
  endtask

  task automatic pop_check(input bit b, input string tag);
    logic [15:0] e;
    chk({tag, "_rvalid"}, 32'(rv(b)), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      last_rd[b] = e;
      chk({tag, "_rdata"}, 32'(rd(b)), 32'(e));
    end
  endtask

  task automatic rd1(input bit b, input logic [4:0] addr, input logic [15:0] e, input string tag);
    set_rd(b, 1'b1, addr);
    exp_q.push_back(e);
    tick;
    set_rd(b, 1'b0, '0);
    pop_check(b, tag);
  endtask

  // Back-to-back reads (re held high) checking 1-cycle latency every cycle.
  task automatic sweep(input bit b, input int n, input int mode, input logic [15:0] v, input string tag);
    for (int i = 0; i < n; i++) begin
      set_rd(b, 1'b1, 5'(i));
      exp_q.push_back(pat(b, mode, i, v));
      tick;
      pop_check(b, tag);
    end
    set_rd(b, 1'b0, '0);
    tick;
    chk({tag, "_rvalid_idle"}, 32'(rv(b)), 32'd0);
  endtask

  task automatic start_fill(input bit b, input logic [1:0] mode, input logic [15:0] v);
    set_req(b, 1'b1, mode, v);
    tick;
    set_req(b, 1'b0, 2'd0, 16'd0);
  endtask

  // Counts busy cycles until the done pulse; the other instance must stay idle.
  task automatic wait_fill(input bit b, input int len, input int already, input string tag);
    int n = already;
    int other = 0;
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (busy(b)) n++;
      else if (done(b)) seen = 1'b1;
      if (busy(!b)) other++;
      if (!seen) tick;
    end
    chk({tag, "_busy_len"}, 32'(n), 32'(len));
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_other_busy"}, 32'(other), 32'd0);
    tick;
    chk({tag, "_done_one_cycle"}, 32'(done(b)), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy(b)), 32'd0);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    set_wr(0, 0, 0, 0);  set_wr(1, 0, 0, 0);
    set_rd(0, 0, 0);     set_rd(1, 0, 0);
    last_rd[0] = '0; last_rd[1] = '0;
    repeat (2) @(negedge clk);

    chk("rst_busy",   32'(a_init_busy), 32'd0);
    chk("rst_done",   32'(a_init_done), 32'd0);
    chk("rst_rdata",  32'(a_rdata), 32'd0);
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_busy", 32'(b_init_busy), 32'd0);

    // Automatic mode-0 fill after reset release.
    rst_n = 1'b1;
    tick;
    wait_fill(0, 32, 0, "autofill");
    sweep(0, 32, 0, 0, "addr_pat");

    // Read-during-write, old-data flavour.
    set_wr(0, 1, 5'd7, 16'h003C);
    set_rd(0, 1, 5'd7);
    exp_q.push_back(16'h0007);
    tick;
    set_wr(0, 0, 0, 0);
    set_rd(0, 0, 0);
    pop_check(0, "rdw_old");
    rd1(0, 5'd7, 16'h003C, "rdw_after");

    // Requested fills: constant, then inverted address.
    start_fill(0, 2'd1, 16'h00A5);
    wait_fill(0, 32, 0, "const_fill");
    sweep(0, 32, 1, 16'h00A5, "const_pat");
    start_fill(0, 2'd3, 16'h0000);
    wait_fill(0, 32, 0, "naddr_fill");
    rd1(0, 5'd5, 16'h00FA, "naddr5");
    rd1(0, 5'd0, 16'h00FF, "naddr0");

    // User access and a second request during a zero fill are ignored.
    start_fill(0, 2'd2, 16'h0000);
    repeat (4) tick;
    set_wr(0, 1, 5'd3, 16'h0055);
    set_rd(0, 1, 5'd3);
    set_req(0, 1, 2'd1, 16'h0077);
    for (int k = 0; k < 20; k++) begin
      tick;
      chk("blk_busy",   32'(a_init_busy), 32'd1);
      chk("blk_rvalid", 32'(a_rvalid), 32'd0);
      chk("blk_rdata",  32'(a_rdata), 32'(last_rd[0]));
    end
    set_wr(0, 0, 0, 0);
    set_rd(0, 0, 0);
    set_req(0, 0, 0, 0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (a_init_done) nd++;
    end
    chk("blk_done_count", 32'(nd), 32'd1);
    chk("blk_busy_end",   32'(a_init_busy), 32'd0);
    sweep(0, 32, 2, 0, "zero_pat");

    // Reset at fill cycle 10 aborts without a done pulse; refill restarts at 0.
    start_fill(0, 2'd1, 16'h0011);
    repeat (9) tick;
    chk("mid_busy_pre", 32'(a_init_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",   32'(a_init_busy), 32'd0);
    chk("mid_rst_done",   32'(a_init_done), 32'd0);
    chk("mid_rst_rdata",  32'(a_rdata), 32'd0);
    chk("mid_rst_rvalid", 32'(a_rvalid), 32'd0);
    @(negedge clk);
    chk("mid_rst_done_hold", 32'(a_init_done), 32'd0);
    rst_n = 1'b1;
    tick;
    wait_fill(0, 32, 0, "refill");
    sweep(0, 32, 0, 0, "refill_pat");

    // Instance B: non-power-of-2 depth, no auto fill, new-data read-during-write.
    chk("b_idle_busy", 32'(b_init_busy), 32'd0);
    set_wr(1, 1, 5'd25, 16'hBEEF);
    tick;
    set_wr(1, 0, 0, 0);
    rd1(1, 5'd25, 16'h0000, "b_oob");
    start_fill(1, 2'd3, 16'h0000);
    wait_fill(1, 20, 0, "b_fill");
    sweep(1, 20, 3, 0, "b_naddr");
    set_wr(1, 1, 5'd7, 16'h003C);
    set_rd(1, 1, 5'd7);
    exp_q.push_back(16'h003C);
    tick;
    set_wr(1, 0, 0, 0);
    set_rd(1, 0, 0);
    pop_check(1, "b_rdw_new");
    rd1(1, 5'd7, 16'h003C, "b_rdw_after");
    rd1(1, 5'd25, 16'h0000, "b_oob2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_init_seq.md
Name: ram_init_seq

Overview:
Parametrised simple-dual-port synchronous RAM with a hardware initialisation sequencer.
- Replaces simulation-only preload with a synthesisable fill engine.
- The fill runs automatically after reset, or on request, using a selectable pattern.
- Used as a generic lookup/scratch memory wherever contents must be known after reset.

Parameters:
- DATA_W, 8, word width in bits (≥1).
- DEPTH, 32, number of words (≥2, need not be a power of 2).
- ADDR_W, $clog2(DEPTH), address width; localparam, not overridable.
- INIT_ON_RESET, 1, 1 = fill starts automatically after reset release.
- INIT_MODE_RST, 0, pattern used for the automatic post-reset fill.
- RDW_NEW, 0, read-during-write to the same address: 0 = return old data, 1 = return new data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- init_req  in  1  single-cycle request to start a fill; honoured only in IDLE.
- init_mode  in  2  fill pattern, sampled with init_req.
- init_value  in  DATA_W  constant for mode 1, sampled with init_req.
- init_busy  out  1  high while a fill is in progress.
- init_done  out  1  one-cycle pulse when a fill completes.
- we  in  1  user write enable.
- waddr  in  ADDR_W  user write address.
- wdata  in  DATA_W  user write data.
- re  in  1  user read enable.
- raddr  in  ADDR_W  user read address.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  high the cycle after an accepted read.

Behaviour:
Reset
- Asynchronous, active-low.
- Outputs reset to: init_busy=0, init_done=0, rdata=0, rvalid=0.
- Reset sets the FSM to START, the fill counter to 0, and the latched mode to INIT_MODE_RST.
- Memory array is not reset; its contents are defined only by a fill or by user writes.

FSM states: START, IDLE, FILL, DONE.
- START: one cycle after reset release. Goes to FILL if INIT_ON_RESET=1, otherwise to IDLE.
- IDLE: init_req=1 latches init_mode and init_value, clears the counter, and goes to FILL.
- FILL:
  - init_busy=1.
  - Writes mem[cnt] = pattern(cnt), then cnt increments, one word per cycle.
  - After writing cnt=DEPTH-1, goes to DONE.
  - The fill takes exactly DEPTH cycles.
- DONE: init_done=1 for one cycle, init_busy=0, then goes to IDLE.

Fill patterns:
- 0: cnt zero-extended or truncated to DATA_W.
- 1: latched init_value.
- 2: all zeros.
- 3: bitwise NOT of mode-0 value.

Arbitration
- While init_busy=1, user we and re are ignored: no write, rvalid=0, rdata holds.
- init_req outside IDLE is ignored, including in START, FILL and DONE.
- A user access is accepted in the DONE cycle.

User access
- Write: takes effect at the clock edge where we=1.
- Read: re=1 at edge N gives rdata and rvalid=1 after edge N. Latency is 1.
- rvalid=0 in any cycle without an accepted read.
- Between reads, rdata holds its last value.
- Same-cycle we and re to the same address: rdata = old word if RDW_NEW=0, wdata if RDW_NEW=1.
- Out-of-range address (≥DEPTH, only when DEPTH is not a power of 2):
  - Write is dropped.
  - Read returns 0 with rvalid=1.

Reset mid-fill
- Aborts the fill immediately; no init_done pulse.
- Re-fills from address 0 if INIT_ON_RESET=1.
- Partially filled contents are otherwise undefined.

Decomposition:
- Shared package ram_init_pkg holds:
  - FSM state enum: ST_START, ST_IDLE, ST_FILL, ST_DONE.
  - Pattern constants: PAT_ADDR=0, PAT_CONST=1, PAT_ZERO=2, PAT_NADDR=3.
- One natural sub-module, ram_sdp_core:
  - Bare storage array, single write port, registered read port, RDW_NEW handling.
  - The top level holds the FSM, the fill counter and the write-port mux.

Test Plan:
1. Defaults, release rst_n, wait → init_busy high for exactly 32 cycles then init_done pulse; reading addresses 0..31 returns 0..31, 1-cycle latency, rvalid each cycle.
2. In IDLE: init_req, init_mode=1, init_value=8'hA5 → 32-cycle fill; all words read 8'hA5. Repeat with mode=3 → addr 5 reads 8'hFA.
3. we=1 at waddr=7 with wdata=8'h3C, and re=1 at raddr=7 in the same cycle → rdata=old word (8'h07 after mode-0 fill) with RDW_NEW=0, or 8'h3C with RDW_NEW=1; next read of addr 7 returns 8'h3C.
4. During a fill: we=1, re=1 and a second init_req → no user write lands, rvalid stays 0, fill completes with a single init_done.
5. Assert rst_n low at fill cycle 10 → outputs reset asynchronously, no init_done; after release a full DEPTH-cycle fill restarts from address 0.
6. DEPTH=20, DATA_W=16, INIT_ON_RESET=0 → no automatic fill, init_busy stays 0; write to addr 25 is dropped; read of addr 25 gives rdata=0 with rvalid=1.
